// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Main control unit for a multicycle MIPS-style datapath. A Moore FSM steps
// each instruction through fetch, decode and the class-specific execute,
// memory and write-back states. It drives the datapath mux selects and the
// write enables for that state.
//
// Build option:
//   JUMP_EN  - when defined, opcode 2 (j) is executed through a JUMP state.
//              When undefined, opcode 2 is treated as an illegal opcode.
//
// Parameters:
//   CNT_W        width of the retired-instruction counter
//
// Ports:
//   CLK          clock; all state changes on the rising edge
//   RESET        asynchronous, active-high reset
//   opcode       instruction[31:26] from the instruction register
//   Zero         ALU zero flag (consumed by the datapath as PCWriteCond & Zero)
//   mem_ready    memory handshake; an access completes in a cycle with it high
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, RegWrite, RegDst, ALUSrcA      1-bit datapath controls
//   ALUOp        ALU control class (00 add, 01 sub/compare, 10 funct decode)
//   ALUSrcB      ALU B select (00 reg, 01 const 4, 10 signext, 11 signext<<2)
//   PCSource     PC source (00 ALU, 01 ALUOut reg, 10 jump target)
//   state        current FSM state
//   err          sticky illegal-opcode flag, cleared only by RESET
//   retired      count of completed instructions, wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [5:0]       opcode,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    localparam logic [5:0] OpRType = 6'd0;
    localparam logic [5:0] OpBeq   = 6'd4;
    localparam logic [5:0] OpLw    = 6'd35;
    localparam logic [5:0] OpSw    = 6'd43;
`ifdef JUMP_EN
    localparam logic [5:0] OpJ     = 6'd2;
`endif

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StRwb    = 4'd7,
        StBranch = 4'd8
`ifdef JUMP_EN
        ,
        StJump   = 4'd9
`endif
    } state_e;

    // Registered control word. The fetch bit marks an active FETCH cycle. The
    // IR and PC write enables in FETCH are that bit qualified by mem_ready.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       fetch;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

    state_e           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             err_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic             illegal;

    // Zero is applied by the datapath (PCWriteCond & Zero), not by this FSM.
    logic unused_zero;
    assign unused_zero = Zero;

    // Control word for a given state. The outputs are registered from the
    // next state, so they change on the same edge as the state they belong to.
    function automatic ctrl_t decode_ctrl(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            StFetch: begin
                c.mem_read  = 1'b1;
                c.fetch     = 1'b1;
                c.alu_src_b = 2'b01;
            end
            StDecode: begin
                c.alu_src_b = 2'b11;  // branch target precompute
            end
            StMemAdr: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            StMemRd: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            StMemWb: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            StExec: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            StRwb: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            StBranch: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
`ifdef JUMP_EN
            StJump: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
`endif
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        illegal = 1'b0;
        case (state_q)
            // The fetch bit is clear on the first edge after reset, so the
            // fetch outputs get one full cycle before any access can complete.
            StFetch: begin
                if (ctrl_q.fetch && mem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (opcode == OpLw || opcode == OpSw) begin
                    state_d = StMemAdr;
                end else if (opcode == OpRType) begin
                    state_d = StExec;
                end else if (opcode == OpBeq) begin
                    state_d = StBranch;
`ifdef JUMP_EN
                end else if (opcode == OpJ) begin
                    state_d = StJump;
`endif
                end else begin
                    state_d = StFetch;
                    illegal = 1'b1;
                end
            end
            StMemAdr: begin
                state_d = (opcode == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                if (mem_ready) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StMemWr: begin
                if (mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StExec: begin
                state_d = StRwb;
            end
            StRwb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StBranch: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
`ifdef JUMP_EN
            StJump: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
`endif
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    assign ctrl_d = decode_ctrl(state_d);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= StFetch;
            ctrl_q    <= '0;
            err_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            if (illegal) begin
                err_q <= 1'b1;
            end
            if (retire) begin
                retired_q <= retired_q + CntOne;
            end
        end
    end

    assign PCWrite     = (ctrl_q.fetch & mem_ready) | ctrl_q.pc_write;
    assign IRWrite     = ctrl_q.fetch & mem_ready;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign IorD        = ctrl_q.i_or_d;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign RegWrite    = ctrl_q.reg_write;
    assign RegDst      = ctrl_q.reg_dst;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUOp       = ctrl_q.alu_op;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign PCSource    = ctrl_q.pc_source;
    assign state       = state_q;
    assign err         = err_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    // Narrow counter so the random run wraps it many times.
    localparam int unsigned CNT_W = 4;

`ifdef JUMP_EN
    localparam bit JumpEn = 1'b1;
`else
    localparam bit JumpEn = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RESET;
    logic [5:0]       opcode;
    logic             Zero;
    logic             mem_ready;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic             MemtoReg, RegWrite, RegDst, ALUSrcA;
    logic [1:0]       ALUOp, ALUSrcB, PCSource;
    logic [3:0]       state;
    logic             err;
    logic [CNT_W-1:0] retired;

    logic [15:0]      ctrl_obs;

    int tests = 0;
    int fails = 0;
    int exp_retired;
    bit exp_err;

    multicycle_control #(
        .CNT_W(CNT_W)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .opcode     (opcode),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .ALUSrcA    (ALUSrcA),
        .ALUOp      (ALUOp),
        .ALUSrcB    (ALUSrcB),
        .PCSource   (PCSource),
        .state      (state),
        .err        (err),
        .retired    (retired)
    );

    always #5 CLK = ~CLK;

    assign ctrl_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, RegWrite, RegDst, ALUSrcA, ALUOp, ALUSrcB, PCSource};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Number of cycles-states an opcode walks through (illegal: fetch+decode).
    function automatic int seq_len(input logic [5:0] op);
        if (op == 6'd35) return 5;
        if (op == 6'd43 || op == 6'd0) return 4;
        if (op == 6'd4) return 3;
        if (op == 6'd2 && JumpEn) return 3;
        return 2;
    endfunction

    // k-th state of the instruction's path.
    function automatic int phase_state(input logic [5:0] op, input int k);
        case (k)
            0: return 0;
            1: return 1;
            2: begin
                if (op == 6'd35 || op == 6'd43) return 2;
                if (op == 6'd0) return 6;
                if (op == 6'd4) return 8;
                return 9;
            end
            3: begin
                if (op == 6'd35) return 3;
                if (op == 6'd43) return 5;
                return 7;
            end
            default: return 4;
        endcase
    endfunction

    function automatic bit is_mem_state(input int st);
        return (st == 0) || (st == 3) || (st == 5);
    endfunction

    // Expected control outputs per state, from the control table.
    function automatic logic [15:0] exp_ctrl(input int st, input bit mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rd, asa;
        logic [1:0] aop, asb, psrc;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rd, asa} = '0;
        aop = 2'b00;
        asb = 2'b00;
        psrc = 2'b00;
        case (st)
            0: begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
            1: asb = 2'b11;
            2: begin asa = 1'b1; asb = 2'b10; end
            3: begin mrd = 1'b1; iord = 1'b1; end
            4: begin rw = 1'b1; m2r = 1'b1; end
            5: begin mwr = 1'b1; iord = 1'b1; end
            6: begin asa = 1'b1; aop = 2'b10; end
            7: begin rw = 1'b1; rd = 1'b1; end
            8: begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
            9: begin pcw = 1'b1; psrc = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rd, asa, aop, asb, psrc};
    endfunction

    task automatic check_cycle(input string tag, input int st, input bit mr);
        check_eq({tag, " state"}, 32'(state), 32'(st));
        check_eq({tag, " ctrl"}, 32'(ctrl_obs), 32'(exp_ctrl(st, mr)));
        check_eq({tag, " retired"}, 32'(retired), 32'(exp_retired));
        check_eq({tag, " err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, " state"}, 32'(state), 32'd0);
        check_eq({tag, " ctrl"}, 32'(ctrl_obs), 32'd0);
        check_eq({tag, " retired"}, 32'(retired), 32'd0);
        check_eq({tag, " err"}, 32'(err), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge CLK);
        RESET = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_eq("post-reset state", 32'(state), 32'd0);
        @(posedge CLK);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        exp_retired = 0;
        exp_err = 1'b0;
        check_reset_values(tag);
        @(negedge CLK);
        release_reset();
    endtask

    // One instruction, checked every cycle. data_stalls: cycles of
    // mem_ready=0 in MEMRD/MEMWR; rand_stalls: random stalls everywhere;
    // zero < 0 randomises Zero.
    task automatic run_instr(input string tag, input logic [5:0] op, input int data_stalls,
                             input bit rand_stalls, input int zero);
        int n;
        int st;
        int waited;
        bit done;
        n = seq_len(op);
        for (int k = 0; k < n; k++) begin
            st = phase_state(op, k);
            waited = 0;
            done = 1'b0;
            while (!done) begin
                @(negedge CLK);
                opcode = op;
                Zero = (zero < 0) ? 1'($urandom_range(0, 1)) : 1'(zero);
                if (is_mem_state(st)) begin
                    if (rand_stalls) mem_ready = (waited >= 4) ? 1'b1 : ($urandom_range(0, 2) != 0);
                    else if (st != 0) mem_ready = (waited >= data_stalls);
                    else mem_ready = 1'b1;
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
                #1;
                check_cycle(tag, st, mem_ready);
                done = !is_mem_state(st) || mem_ready;
                waited++;
                @(posedge CLK);
            end
            if (k == 1 && n == 2) exp_err = 1'b1;
        end
        if (n > 2) exp_retired = (exp_retired + 1) % (1 << CNT_W);
    endtask

    // sw stalled in MEMWR, then RESET asserted between clock edges.
    task automatic reset_in_memwr();
        int path [4];
        path = '{0, 1, 2, 5};
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            opcode = 6'd43;
            mem_ready = (k != 3);
            #1;
            check_cycle("swrst", path[k], mem_ready);
            if (k < 3) @(posedge CLK);
        end
        #2;
        RESET = 1'b1;
        #1;
        exp_retired = 0;
        exp_err = 1'b0;
        check_reset_values("swrst async");
        @(negedge CLK);
        check_reset_values("swrst held");
        release_reset();
    endtask

    function automatic logic [5:0] pick_opcode();
        case ($urandom_range(0, 9))
            0, 1:    return 6'd0;
            2, 8:    return 6'd35;
            3, 9:    return 6'd43;
            4, 5:    return 6'd4;
            6:       return 6'd2;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        RESET = 1'b1;
        opcode = 6'd0;
        Zero = 1'b0;
        mem_ready = 1'b0;
        exp_retired = 0;
        exp_err = 1'b0;

        apply_reset("reset");
        run_instr("rtype", 6'd0, 0, 1'b0, -1);
        run_instr("lw_stall", 6'd35, 3, 1'b0, -1);
        run_instr("beq_z1", 6'd4, 0, 1'b0, 1);
        run_instr("beq_z0", 6'd4, 0, 1'b0, 0);
        run_instr("illegal63", 6'd63, 0, 1'b0, -1);
        run_instr("rtype_after_err", 6'd0, 0, 1'b0, -1);
        run_instr("sw", 6'd43, 1, 1'b0, -1);
        run_instr("jump", 6'd2, 0, 1'b0, -1);
        run_instr("rtype_after_j", 6'd0, 0, 1'b0, -1);
        reset_in_memwr();
        run_instr("rtype_after_rst", 6'd0, 0, 1'b0, -1);

        for (int i = 0; i < 300; i++) begin
            run_instr("rand", pick_opcode(), 0, 1'b1, -1);
        end

        @(negedge CLK);
        #1;
        check_eq("final retired", 32'(retired), 32'(exp_retired));
        check_eq("final err", 32'(err), 32'(exp_err));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
